sd_cmd_scheduler: RTL and testbench
===================================

// Module: sd_cmd_scheduler
// PURPOSE
// Sequences the SD CMD-line engine on behalf of two requesters (0: CPU register interface, 1: SD data/DMA engine).
// Round-robin arbitration; automatic CMD55 prefix for application commands (ACMD); bounded retry on timeout/CRC error.
// Sits between the requesters and the CMD-line engine; exactly one command is in flight at a time.
// PARAMETERS
// RETRIES  2  extra attempts after the first failed attempt (0 = single attempt); whole sequence incl. CMD55 is retried
// PORTS
// i_clk                         in   1   system clock
// i_reset                       in   1   synchronous, active-high reset
// i_rca                         in   16  card RCA; CMD55 argument = {i_rca, 16'h0000}
// i_req                         in   2   request level per requester; fields below held stable while high
// i_req_index                   in   12  {idx1, idx0}, 6 bits each
// i_req_argument                in   64  {arg1, arg0}, 32 bits each
// i_req_long_response           in   2   136-bit response expected
// i_req_skip_response           in   2   no response expected
// i_req_app                     in   2   prefix with CMD55 (ACMD)
// o_req_done                    out  2   one-cycle completion pulse to the granted requester
// o_busy                        out  1   high whenever state != IDLE
// o_response_index              out  6   index field of last received response
// o_response                    out  32  response word from engine (valid with o_req_done)
// o_timeout                     out  1   final attempt timed out (valid with o_req_done)
// o_crc_error                   out  1   final attempt had CRC error or CMD55 APP_CMD not set (valid with o_req_done)
// o_command_index               out  6   to engine
// o_command_argument            out  32  to engine
// o_command_long_response       out  1   to engine
// o_command_skip_response       out  1   to engine
// o_command_start               out  1   one-cycle start pulse to engine
// i_command_busy                in   1   engine busy (rises the cycle after o_command_start)
// i_command_index               in   6   engine response index
// i_command_response            in   32  engine response
// i_command_timeout             in   1   engine timeout flag
// i_command_response_crc_error  in   1   engine CRC flag (sticky; not cleared by engine on start)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; round-robin pointer favours requester 0; retry counter 0. Reset mid-command aborts, no done pulse.
// - States: IDLE -> (APP_ISSUE -> APP_WAIT ->) ISSUE -> WAIT -> DONE -> IDLE.
// - IDLE: if any i_req, grant one: both high -> the requester not granted last; latch its fields; clear retry counter.
//   Next state APP_ISSUE if app, else ISSUE.
// - APP_ISSUE: drive index 55, arg {i_rca,16'h0}, long=0, skip=0; pulse o_command_start for 1 cycle; -> APP_WAIT.
// - ISSUE: drive latched fields; pulse o_command_start for 1 cycle; -> WAIT.
// - APP_WAIT/WAIT: first cycle ignores i_command_busy (engine busy not yet visible); thereafter exit when !i_command_busy.
// - Outcome evaluation at exit:
//   - skip=1: always success.
//   - else timeout=i_command_timeout; crc = !timeout && i_command_response_crc_error.
//   - CMD55 additionally fails if response bit 5 (APP_CMD) is 0.
// - Failure with retry counter < RETRIES: counter++, restart at APP_ISSUE (app) or ISSUE.
// - Failure with counter == RETRIES: -> DONE with flags. CMD55 failure never issues the main command.
// - Success of CMD55 -> ISSUE; success of main command -> DONE.
// - DONE (1 cycle): o_req_done[granted]=1; o_response/o_response_index/o_timeout/o_crc_error registered and held until next DONE.
//   Skip: o_response=0, flags 0. Update round-robin pointer; -> IDLE.
// - Requester must deassert i_req the cycle after o_req_done; IDLE samples it again then.
// - Engine command outputs hold their last values outside ISSUE/APP_ISSUE. o_command_start is never asserted while i_command_busy is high.
// - Latency: idle request to o_command_start = 2 cycles (grant, issue).
// TESTING
// - req0 idx 17 arg 0x0000_1000 -> start idx 17, engine R1 0x0000_0900 -> o_req_done=01, o_response=0x0000_0900, flags 0.
// - req0 and req1 both high from reset -> req0 served first, then req1; repeat -> order alternates 0,1,0,1.
// - req1 app idx 41, i_rca=0x1234 -> CMD55 arg 0x1234_0000 (resp bit5=1), then CMD41; exactly 2 starts, one done pulse.
// - CMD55 response bit5=0, RETRIES=2 -> 3 CMD55 attempts, no CMD41, done with o_crc_error=1.
// - Engine timeout on every attempt, RETRIES=2 -> 3 starts, o_timeout=1, o_crc_error=0 despite stale engine CRC flag=1.
// - i_reset in WAIT -> next cycle IDLE, o_busy=0, no o_req_done; req still high -> re-issued with retry counter 0.

Source files
------------

// File: rtl/sd_cmd_scheduler.sv
// sd_cmd_scheduler
// Sequences the SD CMD-line engine for two requesters (0: CPU register
// interface, 1: data/DMA engine). Round-robin grant, automatic CMD55 prefix
// for application commands, bounded retry of the whole sequence on timeout,
// CRC error or missing APP_CMD status. One command is in flight at a time.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_rca                       card RCA (CMD55 argument upper half)
//   i_req / i_req_*             per-requester request level and fields
//   o_req_done                  one-cycle completion pulse to granted requester
//   o_busy                      scheduler not idle
//   o_response*, o_timeout,
//   o_crc_error                 result of the final attempt, held until next done
//   o_command_*                 command fields and start pulse to the engine
//   i_command_*                 engine status and response
module sd_cmd_scheduler #(
  parameter int unsigned RETRIES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_rca,
  input  logic [1:0]  i_req,
  input  logic [11:0] i_req_index,
  input  logic [63:0] i_req_argument,
  input  logic [1:0]  i_req_long_response,
  input  logic [1:0]  i_req_skip_response,
  input  logic [1:0]  i_req_app,
  output logic [1:0]  o_req_done,
  output logic        o_busy,
  output logic [5:0]  o_response_index,
  output logic [31:0] o_response,
  output logic        o_timeout,
  output logic        o_crc_error,
  output logic [5:0]  o_command_index,
  output logic [31:0] o_command_argument,
  output logic        o_command_long_response,
  output logic        o_command_skip_response,
  output logic        o_command_start,
  input  logic        i_command_busy,
  input  logic [5:0]  i_command_index,
  input  logic [31:0] i_command_response,
  input  logic        i_command_timeout,
  input  logic        i_command_response_crc_error
);

  localparam int unsigned CW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  localparam logic [CW-1:0] RETRY_MAX = CW'(RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APP_ISSUE,
    S_APP_WAIT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic          grant;
  logic          last_grant;
  logic [5:0]    req_index;
  logic [31:0]   req_argument;
  logic          req_long;
  logic          req_skip;
  logic          req_app;
  logic [CW-1:0] retry;
  logic          wait_first;

  logic grant_sel;
  logic exit_wait;
  logic eval_skip;
  logic eval_timeout;
  logic eval_crc;
  logic fail;
  logic can_retry;

  // Both requesting: take the one not served last; otherwise whoever asks.
  always_comb begin
    grant_sel = i_req[1] & (~i_req[0] | ~last_grant);
  end

  // The engine's busy flag only becomes visible one cycle after start, so
  // the first wait cycle never exits. The CRC flag is sticky in the engine,
  // hence it is masked by timeout.
  always_comb begin
    exit_wait    = (state == S_APP_WAIT || state == S_WAIT) && !wait_first && !i_command_busy;
    eval_skip    = (state == S_WAIT) && req_skip;
    eval_timeout = !eval_skip && i_command_timeout;
    eval_crc     = !eval_skip && !i_command_timeout &&
                   (i_command_response_crc_error ||
                    (state == S_APP_WAIT && !i_command_response[5]));
    fail         = eval_timeout || eval_crc;
    can_retry    = retry < RETRY_MAX;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (|i_req) begin
          state_next = (grant_sel ? i_req_app[1] : i_req_app[0]) ? S_APP_ISSUE : S_ISSUE;
        end
      end
      S_APP_ISSUE: state_next = S_APP_WAIT;
      S_ISSUE:     state_next = S_WAIT;
      S_APP_WAIT: begin
        if (exit_wait) begin
          if (!fail)          state_next = S_ISSUE;
          else if (can_retry) state_next = S_APP_ISSUE;
          else                state_next = S_DONE;
        end
      end
      S_WAIT: begin
        if (exit_wait) begin
          if (fail && can_retry) state_next = req_app ? S_APP_ISSUE : S_ISSUE;
          else                   state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_done = '0;
    if (state == S_DONE) begin
      o_req_done[grant] = 1'b1;
    end
    o_busy = (state != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                   <= S_IDLE;
      grant                   <= 1'b0;
      last_grant              <= 1'b1;
      req_index               <= '0;
      req_argument            <= '0;
      req_long                <= 1'b0;
      req_skip                <= 1'b0;
      req_app                 <= 1'b0;
      retry                   <= '0;
      wait_first              <= 1'b0;
      o_response_index        <= '0;
      o_response              <= '0;
      o_timeout               <= 1'b0;
      o_crc_error             <= 1'b0;
      o_command_index         <= '0;
      o_command_argument      <= '0;
      o_command_long_response <= 1'b0;
      o_command_skip_response <= 1'b0;
      o_command_start         <= 1'b0;
    end else begin
      state           <= state_next;
      wait_first      <= (state == S_ISSUE || state == S_APP_ISSUE);
      o_command_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|i_req) begin
            grant        <= grant_sel;
            req_index    <= grant_sel ? i_req_index[11:6]     : i_req_index[5:0];
            req_argument <= grant_sel ? i_req_argument[63:32] : i_req_argument[31:0];
            req_long     <= grant_sel ? i_req_long_response[1] : i_req_long_response[0];
            req_skip     <= grant_sel ? i_req_skip_response[1] : i_req_skip_response[0];
            req_app      <= grant_sel ? i_req_app[1]           : i_req_app[0];
            retry        <= '0;
          end
        end
        S_APP_ISSUE: begin
          o_command_index         <= 6'd55;
          o_command_argument      <= {i_rca, 16'h0000};
          o_command_long_response <= 1'b0;
          o_command_skip_response <= 1'b0;
          o_command_start         <= 1'b1;
        end
        S_ISSUE: begin
          o_command_index         <= req_index;
          o_command_argument      <= req_argument;
          o_command_long_response <= req_long;
          o_command_skip_response <= req_skip;
          o_command_start         <= 1'b1;
        end
        S_APP_WAIT, S_WAIT: begin
          if (exit_wait && fail && can_retry) begin
            retry <= retry + 1'b1;
          end
          if (state_next == S_DONE) begin
            o_response       <= eval_skip ? '0 : i_command_response;
            o_response_index <= eval_skip ? '0 : i_command_index;
            o_timeout        <= eval_timeout;
            o_crc_error      <= eval_crc;
          end
        end
        S_DONE: begin
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
module tb_sd_cmd_scheduler;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_rca = '0;
  logic [1:0]  i_req = '0;
  logic [11:0] i_req_index = '0;
  logic [63:0] i_req_argument = '0;
  logic [1:0]  i_req_long_response = '0;
  logic [1:0]  i_req_skip_response = '0;
  logic [1:0]  i_req_app = '0;
  logic [1:0]  o_req_done;
  logic        o_busy;
  logic [5:0]  o_response_index;
  logic [31:0] o_response;
  logic        o_timeout;
  logic        o_crc_error;
  logic [5:0]  o_command_index;
  logic [31:0] o_command_argument;
  logic        o_command_long_response;
  logic        o_command_skip_response;
  logic        o_command_start;
  logic        i_command_busy = 1'b0;
  logic [5:0]  i_command_index = '0;
  logic [31:0] i_command_response = '0;
  logic        i_command_timeout = 1'b0;
  logic        i_command_response_crc_error = 1'b0;

  always #5 clk = ~clk;

  sd_cmd_scheduler #(.RETRIES(2)) dut (
    .i_clk                        (clk),
    .i_reset                      (i_reset),
    .i_rca                        (i_rca),
    .i_req                        (i_req),
    .i_req_index                  (i_req_index),
    .i_req_argument               (i_req_argument),
    .i_req_long_response          (i_req_long_response),
    .i_req_skip_response          (i_req_skip_response),
    .i_req_app                    (i_req_app),
    .o_req_done                   (o_req_done),
    .o_busy                       (o_busy),
    .o_response_index             (o_response_index),
    .o_response                   (o_response),
    .o_timeout                    (o_timeout),
    .o_crc_error                  (o_crc_error),
    .o_command_index              (o_command_index),
    .o_command_argument           (o_command_argument),
    .o_command_long_response      (o_command_long_response),
    .o_command_skip_response      (o_command_skip_response),
    .o_command_start              (o_command_start),
    .i_command_busy               (i_command_busy),
    .i_command_index              (i_command_index),
    .i_command_response           (i_command_response),
    .i_command_timeout            (i_command_timeout),
    .i_command_response_crc_error (i_command_response_crc_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model: busy rises the cycle after start, stays up a few cycles.
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          start_busy = 0;
  int          eng_cnt = 0;
  logic        eng_pend = 1'b0;
  logic [5:0]  st_idx [0:63];
  logic [31:0] st_arg [0:63];

  always @(negedge clk) begin
    if (i_reset) begin
      i_command_busy = 1'b0;
      eng_pend = 1'b0;
      eng_cnt = 0;
    end else if (o_command_start) begin
      if (i_command_busy) start_busy++;
      if (start_cnt < 64) begin
        st_idx[start_cnt] = o_command_index;
        st_arg[start_cnt] = o_command_argument;
      end
      start_cnt++;
      eng_pend = 1'b1;
    end else if (eng_pend) begin
      eng_pend = 1'b0;
      i_command_busy = 1'b1;
      eng_cnt = 3;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) i_command_busy = 1'b0;
    end
    if (|o_req_done) done_cnt++;
  end

  task automatic wait_done(input int maxc, output logic [1:0] d);
    d = '0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (|o_req_done) begin
        d = o_req_done;
        break;
      end
    end
  endtask

  task automatic wait_starts(input int base, input int n, input int maxc, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (start_cnt - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  logic [1:0] d;
  logic       ok;
  int         s0, d0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_req_done, 0);
    check("rst_start", o_command_start, 0);
    check("rst_resp", o_response, 0);
    check("rst_cmd_idx", o_command_index, 0);
    check("rst_flags", {o_timeout, o_crc_error}, 0);
    i_reset = 1'b0;
    @(negedge clk);

    // Plain command, 2-cycle latency to start
    i_command_response = 32'h0000_0900;
    i_command_index = 6'd17;
    s0 = start_cnt;
    i_req_index = {6'd0, 6'd17};
    i_req_argument = {32'h0, 32'h0000_1000};
    i_req = 2'b01;
    @(negedge clk);
    check("lat_no_start_yet", o_command_start, 0);
    check("lat_busy", o_busy, 1);
    @(negedge clk);
    check("lat_start", o_command_start, 1);
    check("start_idx", o_command_index, 17);
    check("start_arg", o_command_argument, 32'h0000_1000);
    wait_done(60, d);
    i_req = '0;
    check("plain_done", d, 2'b01);
    check("plain_resp", o_response, 32'h0000_0900);
    check("plain_resp_idx", o_response_index, 17);
    check("plain_flags", {o_timeout, o_crc_error}, 0);
    check("plain_starts", start_cnt - s0, 1);
    repeat (2) @(negedge clk);
    check("plain_idle", o_busy, 0);

    // Round-robin from reset with both requesting
    i_req_index = {6'd2, 6'd1};
    i_req = 2'b11;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      wait_done(60, d);
      i_req = 2'b10;
      check("rr_first", d, 2'b01);
      wait_done(60, d);
      i_req = 2'b00;
      check("rr_second", d, 2'b10);
      @(negedge clk);
      i_req = 2'b11;
    end
    i_req = 2'b00;
    repeat (2) @(negedge clk);

    // ACMD41 from requester 1: CMD55 then CMD41
    i_rca = 16'h1234;
    i_command_response = 32'h0000_0120;
    s0 = start_cnt;
    d0 = done_cnt;
    i_req_app = 2'b10;
    i_req_index = {6'd41, 6'd0};
    i_req_argument = {32'h40FF_8000, 32'h0};
    i_req = 2'b10;
    wait_done(120, d);
    i_req = '0;
    i_req_app = '0;
    repeat (5) @(negedge clk);
    check("app_done", d, 2'b10);
    check("app_starts", start_cnt - s0, 2);
    check("app_cmd55_idx", st_idx[s0], 55);
    check("app_cmd55_arg", st_arg[s0], 32'h1234_0000);
    check("app_main_idx", st_idx[s0+1], 41);
    check("app_main_arg", st_arg[s0+1], 32'h40FF_8000);
    check("app_one_done", done_cnt - d0, 1);
    check("app_flags", {o_timeout, o_crc_error}, 0);
    check("app_resp", o_response, 32'h0000_0120);

    // APP_CMD bit clear: three CMD55 attempts, main command never issued
    i_command_response = 32'h0000_0100;
    s0 = start_cnt;
    i_req_app = 2'b01;
    i_req_index = {6'd0, 6'd41};
    i_req_argument = {32'h0, 32'h00FF_8000};
    i_req = 2'b01;
    wait_done(200, d);
    i_req = '0;
    i_req_app = '0;
    repeat (3) @(negedge clk);
    check("nac_done", d, 2'b01);
    check("nac_starts", start_cnt - s0, 3);
    check("nac_third_idx", st_idx[s0+2], 55);
    check("nac_crc", o_crc_error, 1);
    check("nac_timeout", o_timeout, 0);

    // Timeout on every attempt with stale CRC flag set
    i_command_timeout = 1'b1;
    i_command_response_crc_error = 1'b1;
    s0 = start_cnt;
    i_req_index = {6'd0, 6'd8};
    i_req_argument = '0;
    i_req = 2'b01;
    wait_done(200, d);
    i_req = '0;
    repeat (3) @(negedge clk);
    check("to_done", d, 2'b01);
    check("to_starts", start_cnt - s0, 3);
    check("to_timeout", o_timeout, 1);
    check("to_crc", o_crc_error, 0);

    // Skip-response command: always success, response zeroed
    i_command_timeout = 1'b0;
    i_command_response = 32'h0000_0900;
    s0 = start_cnt;
    i_req_skip_response = 2'b01;
    i_req_index = {6'd0, 6'd0};
    i_req = 2'b01;
    wait_done(60, d);
    i_req = '0;
    i_req_skip_response = '0;
    repeat (3) @(negedge clk);
    check("skip_done", d, 2'b01);
    check("skip_resp", o_response, 0);
    check("skip_flags", {o_timeout, o_crc_error}, 0);
    check("skip_starts", start_cnt - s0, 1);

    // CRC error on first attempt only: one retry then success
    s0 = start_cnt;
    i_req_index = {6'd0, 6'd17};
    i_req = 2'b01;
    wait_starts(s0, 2, 100, ok);
    i_command_response_crc_error = 1'b0;
    check("crc_retry_started", ok, 1);
    wait_done(100, d);
    i_req = '0;
    repeat (3) @(negedge clk);
    check("crc_done", d, 2'b01);
    check("crc_starts", start_cnt - s0, 2);
    check("crc_flags", {o_timeout, o_crc_error}, 0);

    // Reset in WAIT after one retry: aborted, then re-issued from retry 0
    i_command_timeout = 1'b1;
    s0 = start_cnt;
    d0 = done_cnt;
    i_req_index = {6'd0, 6'd9};
    i_req = 2'b01;
    wait_starts(s0, 2, 100, ok);
    check("rw_second_start", ok, 1);
    i_reset = 1'b1;
    @(negedge clk);
    check("rw_busy", o_busy, 0);
    check("rw_done", o_req_done, 0);
    check("rw_start", o_command_start, 0);
    @(negedge clk);
    i_reset = 1'b0;
    check("rw_no_done_pulse", done_cnt - d0, 0);
    s0 = start_cnt;
    wait_done(200, d);
    i_req = '0;
    repeat (3) @(negedge clk);
    check("rw_redone", d, 2'b01);
    check("rw_restarts", start_cnt - s0, 3);
    check("rw_timeout", o_timeout, 1);

    check("no_start_while_busy", start_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
